fb_cmd_engine: RTL and testbench

//  Parametrised framebuffer/palette command engine. Consumes the COBS-decoded byte

---
 rtl/fb_cmd_engine.sv | 247 ++++++++++++++++++++++++
 tb/tb_fb_cmd_engine.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_cmd_engine.sv
// fb_cmd_engine: turns COBS-decoded command frames into VRAM and palette RAM
// write cycles. One frame carries one command; the first byte (in_sof=1) is
// the opcode and the rest is that command's payload.
module fb_cmd_engine #(
    parameter int VADDR_W = 15,
    parameter int PAL_AW  = 4,
    parameter int PAL_W   = 12,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               vram_we,
    output logic [VADDR_W-1:0] vram_addr,
    output logic [7:0]         vram_din,
    input  logic               vram_ready,
    output logic               pram_we,
    output logic [PAL_AW-1:0]  pram_addr,
    output logic [PAL_W-1:0]   pram_din,
    output logic               busy,
    output logic [7:0]         err_cnt
);

    // Number of payload bytes in an ADDR command, and the width of the shadow
    // register holding every address byte except the last one.
    localparam int ABYTES = (VADDR_W + 7) / 8;
    localparam int SHW    = (ABYTES > 1) ? (ABYTES - 1) * 8 : 8;
    localparam int IDX_W  = 4;
    localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ABYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_ADDR,
        ST_FILL,
        ST_PAL,
        ST_PSEL,
        ST_IGNORE
    } state_t;

    state_t             state_q, state_d;
    logic [VADDR_W-1:0] vaddr_q, vaddr_d;
    logic [PAL_AW-1:0]  paddr_q, paddr_d;
    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [SHW-1:0]     addr_shadow_q, addr_shadow_d;
    logic [7:0]         fill_val_q, fill_val_d;
    logic [7:0]         cnt_lo_q, cnt_lo_d;
    logic [CNT_W-1:0]   fill_rem_q, fill_rem_d;
    logic               filling_q, filling_d;
    logic               vram_we_q, vram_we_d;
    logic [7:0]         vram_din_q, vram_din_d;
    logic [7:0]         pal_lo_q, pal_lo_d;
    logic               pram_we_q, pram_we_d;
    logic [PAL_AW-1:0]  pram_addr_q, pram_addr_d;
    logic [PAL_W-1:0]   pram_din_q, pram_din_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    logic               accept;
    logic               write_done;
    logic               err_inc;
    logic [CNT_W-1:0]   fill_cnt;

    // A byte is only taken while no VRAM write is outstanding, so the write
    // port never has to queue more than the single held request.
    assign in_ready   = !vram_we_q && !filling_q;
    assign accept     = in_valid && in_ready;
    assign write_done = vram_we_q && vram_ready;
    assign fill_cnt   = CNT_W'({in_data, cnt_lo_q});

    assign vram_we    = vram_we_q;
    assign vram_addr  = vaddr_q;
    assign vram_din   = vram_din_q;
    assign pram_we    = pram_we_q;
    assign pram_addr  = pram_addr_q;
    assign pram_din   = pram_din_q;
    assign busy       = vram_we_q | filling_q;
    assign err_cnt    = err_cnt_q;

    // Command decode, payload collection and write sequencing.
    always_comb begin
        state_d       = state_q;
        vaddr_d       = vaddr_q;
        paddr_d       = paddr_q;
        byte_idx_d    = byte_idx_q;
        addr_shadow_d = addr_shadow_q;
        fill_val_d    = fill_val_q;
        cnt_lo_d      = cnt_lo_q;
        fill_rem_d    = fill_rem_q;
        filling_d     = filling_q;
        vram_we_d     = vram_we_q;
        vram_din_d    = vram_din_q;
        pal_lo_d      = pal_lo_q;
        pram_we_d     = 1'b0;
        pram_addr_d   = pram_addr_q;
        pram_din_d    = pram_din_q;
        err_cnt_d     = err_cnt_q;
        err_inc       = 1'b0;

        // A completed VRAM write always advances the address; during a FILL
        // the request stays up until the last of the run has been accepted.
        if (write_done) begin
            vaddr_d = vaddr_q + VADDR_W'(1);
            if (filling_q) begin
                if (fill_rem_q == CNT_W'(1)) begin
                    filling_d = 1'b0;
                    vram_we_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    fill_rem_d = fill_rem_q - CNT_W'(1);
                end
            end else begin
                vram_we_d = 1'b0;
            end
        end

        if (accept) begin
            if (in_sof) begin
                // Opcodes restart decoding from any state; half-collected
                // payload bytes are simply abandoned.
                byte_idx_d = '0;
                case (in_data[2:0])
                    3'd1: state_d = ST_DATA;
                    3'd2: state_d = ST_ADDR;
                    3'd3: state_d = ST_FILL;
                    3'd4: begin
                        state_d = ST_PAL;
                        paddr_d = '0;
                    end
                    3'd5: state_d = ST_PSEL;
                    default: begin
                        state_d = ST_IGNORE;
                        err_inc = 1'b1;
                    end
                endcase
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        err_inc = 1'b1;
                    end
                    ST_DATA: begin
                        vram_we_d  = 1'b1;
                        vram_din_d = in_data;
                    end
                    ST_ADDR: begin
                        if (byte_idx_q == ADDR_LAST) begin
                            if (ABYTES == 1) begin
                                vaddr_d = VADDR_W'(in_data);
                            end else begin
                                vaddr_d = VADDR_W'({in_data, addr_shadow_q});
                            end
                            state_d    = ST_DATA;
                            byte_idx_d = '0;
                        end else begin
                            addr_shadow_d = SHW'({in_data, addr_shadow_q} >> 8);
                            byte_idx_d    = byte_idx_q + IDX_W'(1);
                        end
                    end
                    ST_FILL: begin
                        if (byte_idx_q == IDX_W'(0)) begin
                            fill_val_d = in_data;
                            byte_idx_d = IDX_W'(1);
                        end else if (byte_idx_q == IDX_W'(1)) begin
                            cnt_lo_d   = in_data;
                            byte_idx_d = IDX_W'(2);
                        end else begin
                            byte_idx_d = '0;
                            if (fill_cnt != '0) begin
                                fill_rem_d = fill_cnt;
                                filling_d  = 1'b1;
                                vram_we_d  = 1'b1;
                                vram_din_d = fill_val_q;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                    ST_PAL: begin
                        if (byte_idx_q == IDX_W'(0)) begin
                            pal_lo_d   = in_data;
                            byte_idx_d = IDX_W'(1);
                        end else begin
                            pram_we_d   = 1'b1;
                            pram_addr_d = paddr_q;
                            pram_din_d  = PAL_W'({in_data, pal_lo_q});
                            paddr_d     = paddr_q + PAL_AW'(1);
                            byte_idx_d  = '0;
                        end
                    end
                    ST_PSEL: begin
                        paddr_d    = in_data[PAL_AW-1:0];
                        state_d    = ST_PAL;
                        byte_idx_d = '0;
                    end
                    default: begin
                    end
                endcase
            end
        end

        if (err_inc && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State and datapath registers; reset abandons any write in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            vaddr_q       <= '0;
            paddr_q       <= '0;
            byte_idx_q    <= '0;
            addr_shadow_q <= '0;
            fill_val_q    <= '0;
            cnt_lo_q      <= '0;
            fill_rem_q    <= '0;
            filling_q     <= 1'b0;
            vram_we_q     <= 1'b0;
            vram_din_q    <= '0;
            pal_lo_q      <= '0;
            pram_we_q     <= 1'b0;
            pram_addr_q   <= '0;
            pram_din_q    <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            vaddr_q       <= vaddr_d;
            paddr_q       <= paddr_d;
            byte_idx_q    <= byte_idx_d;
            addr_shadow_q <= addr_shadow_d;
            fill_val_q    <= fill_val_d;
            cnt_lo_q      <= cnt_lo_d;
            fill_rem_q    <= fill_rem_d;
            filling_q     <= filling_d;
            vram_we_q     <= vram_we_d;
            vram_din_q    <= vram_din_d;
            pal_lo_q      <= pal_lo_d;
            pram_we_q     <= pram_we_d;
            pram_addr_q   <= pram_addr_d;
            pram_din_q    <= pram_din_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_fb_cmd_engine.sv
// tb_fb_cmd_engine: directed and randomized frames for fb_cmd_engine, checked
// against a frame-level reference model of the command set.
module tb_fb_cmd_engine;

    localparam int VADDR_W = 15;
    localparam int PAL_AW  = 4;
    localparam int PAL_W   = 12;
    localparam int CNT_W   = 16;
    localparam int VMASK   = (1 << VADDR_W) - 1;
    localparam int PMASK   = (1 << PAL_W) - 1;
    localparam int PDEPTH  = 1 << PAL_AW;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_sof;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               vram_we;
    logic [VADDR_W-1:0] vram_addr;
    logic [7:0]         vram_din;
    logic               vram_ready;
    logic               pram_we;
    logic [PAL_AW-1:0]  pram_addr;
    logic [PAL_W-1:0]   pram_din;
    logic               busy;
    logic [7:0]         err_cnt;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic [7:0]  curFrame[$];
    logic [31:0] expVram[$];
    logic [31:0] expPram[$];
    logic [31:0] vramLog[$];
    logic [31:0] pramLog[$];
    int          vPtr = 0;
    int          pPtr = 0;
    int          mVaddr = 0;
    int          mPaddr = 0;
    int          mErr = 0;
    int          gapMax = 0;
    logic        holdArm;
    logic        readyRandom;
    logic        overlapSeen = 1'b0;

    fb_cmd_engine #(
        .VADDR_W(VADDR_W),
        .PAL_AW (PAL_AW),
        .PAL_W  (PAL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .vram_we   (vram_we),
        .vram_addr (vram_addr),
        .vram_din  (vram_din),
        .vram_ready(vram_ready),
        .pram_we   (pram_we),
        .pram_addr (pram_addr),
        .pram_din  (pram_din),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // VRAM arbitration stand-in: always ready, randomly ready, or held off
    // for the first three cycles of one armed write.
    initial begin
        int holdCount;
        holdCount  = 0;
        vram_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (holdArm && vram_we && holdCount < 3) begin
                vram_ready = 1'b0;
                holdCount++;
            end else if (readyRandom) begin
                vram_ready = ($urandom_range(0, 3) != 0);
            end else begin
                vram_ready = 1'b1;
            end
        end
    end

    // Records every completed VRAM write and every palette strobe.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (vram_we && vram_ready) vramLog.push_back(32'({vram_addr, vram_din}));
            if (pram_we) pramLog.push_back((32'(pram_addr) << 16) | 32'(pram_din));
            if (vram_we && pram_we) overlapSeen = 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic void modelError();
        if (mErr < 255) mErr++;
    endfunction

    function automatic void modelWrite(input logic [7:0] d);
        expVram.push_back(32'(mVaddr * 256 + int'(d)));
        mVaddr = (mVaddr + 1) & VMASK;
    endfunction

    function automatic void modelPairs(input int start);
        for (int i = start; i + 1 < curFrame.size(); i += 2) begin
            expPram.push_back(32'((mPaddr << 16) | (((int'(curFrame[i+1]) << 8) | int'(curFrame[i])) & PMASK)));
            mPaddr = (mPaddr + 1) % PDEPTH;
        end
    endfunction

    // Whole-frame effect of one command on the expected write streams.
    function automatic void modelFrame();
        int         n;
        int         cnt;
        logic [7:0] op;
        n = curFrame.size();
        if (n == 0) return;
        op = curFrame[0];
        case (op[2:0])
            3'd1: for (int i = 1; i < n; i++) modelWrite(curFrame[i]);
            3'd2: if (n >= 3) begin
                mVaddr = (int'(curFrame[1]) | (int'(curFrame[2]) << 8)) & VMASK;
                for (int i = 3; i < n; i++) modelWrite(curFrame[i]);
            end
            3'd3: if (n >= 4) begin
                cnt = int'(curFrame[2]) | (int'(curFrame[3]) << 8);
                for (int k = 0; k < cnt; k++) modelWrite(curFrame[1]);
                for (int i = 4; i < n; i++) modelError();
            end
            3'd4: begin
                mPaddr = 0;
                modelPairs(1);
            end
            3'd5: if (n >= 2) begin
                mPaddr = int'(curFrame[1]) % PDEPTH;
                modelPairs(2);
            end
            default: modelError();
        endcase
    endfunction

    task automatic sendByte(input logic [7:0] d, input logic sof);
        int waitCycles;
        waitCycles = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        @(negedge clk);
        while (!in_ready && waitCycles < 1000) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic applyStimulus();
        int gap;
        for (int i = 0; i < curFrame.size(); i++) begin
            sendByte(curFrame[i], i == 0);
            gap = (gapMax > 0) ? $urandom_range(0, gapMax) : 0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
        end
        modelFrame();
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idle_timeout", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic compareLogs(input string tag);
        checkOutput({tag, "_vcount"}, 32'(vramLog.size() - vPtr), 32'(expVram.size()));
        for (int i = 0; i < expVram.size(); i++)
            if (vPtr + i < vramLog.size()) checkOutput({tag, "_vram"}, vramLog[vPtr+i], expVram[i]);
        checkOutput({tag, "_pcount"}, 32'(pramLog.size() - pPtr), 32'(expPram.size()));
        for (int i = 0; i < expPram.size(); i++)
            if (pPtr + i < pramLog.size()) checkOutput({tag, "_pram"}, pramLog[pPtr+i], expPram[i]);
        vPtr = vramLog.size();
        pPtr = pramLog.size();
        expVram.delete();
        expPram.delete();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_vram_we"}, 32'(vram_we), 32'd0);
        checkOutput({tag, "_vram_addr"}, 32'(vram_addr), 32'd0);
        checkOutput({tag, "_vram_din"}, 32'(vram_din), 32'd0);
        checkOutput({tag, "_pram_we"}, 32'(pram_we), 32'd0);
        checkOutput({tag, "_pram_addr"}, 32'(pram_addr), 32'd0);
        checkOutput({tag, "_pram_din"}, 32'(pram_din), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        int         busyCycles;
        int         kind;
        int         len;
        logic [7:0] op;

        rst         = 1'b0;
        in_valid    = 1'b0;
        in_sof      = 1'b0;
        in_data     = 8'h00;
        holdArm     = 1'b0;
        readyRandom = 1'b0;

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] DATA frame and continuation");
        curFrame = '{8'h01, 8'hAA, 8'hBB, 8'hCC};
        applyStimulus();
        waitIdle();
        compareLogs("data");
        curFrame = '{8'h01, 8'h5A};
        applyStimulus();
        waitIdle();
        compareLogs("data_cont");

        $display("[TB] ADDR then data with held write");
        holdArm  = 1'b1;
        curFrame = '{8'h02, 8'hFE, 8'h7F, 8'h11, 8'h22};
        for (int i = 0; i < 4; i++) sendByte(curFrame[i], i == 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("hold_vram_we", 32'(vram_we), 32'd1);
            checkOutput("hold_vram_addr", 32'(vram_addr), 32'h7FFE);
            checkOutput("hold_vram_din", 32'(vram_din), 32'h11);
        end
        @(posedge clk);
        #1;
        sendByte(curFrame[4], 1'b0);
        modelFrame();
        waitIdle();
        holdArm = 1'b0;
        compareLogs("addr_hold");

        $display("[TB] address wrap");
        curFrame = '{8'h02, 8'hFF, 8'h7F};
        applyStimulus();
        curFrame = '{8'h01, 8'h55, 8'h66};
        applyStimulus();
        waitIdle();
        compareLogs("wrap");

        $display("[TB] FILL run and empty FILL");
        curFrame = '{8'h03, 8'hE7, 8'h05, 8'h00};
        for (int i = 0; i < 4; i++) sendByte(curFrame[i], i == 0);
        busyCycles = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) break;
            busyCycles++;
        end
        checkOutput("fill_busy_cycles", 32'(busyCycles), 32'd5);
        @(posedge clk);
        #1;
        modelFrame();
        compareLogs("fill");
        curFrame = '{8'h03, 8'h12, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) sendByte(curFrame[i], i == 0);
        @(negedge clk);
        checkOutput("fill0_busy", 32'(busy), 32'd0);
        checkOutput("fill0_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        modelFrame();
        waitIdle();
        compareLogs("fill0");

        $display("[TB] palette writes");
        curFrame = '{8'h04, 8'h34, 8'h0A, 8'h78, 8'h05};
        applyStimulus();
        waitIdle();
        compareLogs("pal");
        curFrame = '{8'h05, 8'h0F, 8'hFF, 8'h0F, 8'h01, 8'h02};
        applyStimulus();
        waitIdle();
        compareLogs("psel");

        $display("[TB] error counting");
        curFrame = '{8'h07};
        for (int i = 0; i < 300; i++) curFrame.push_back(8'($urandom_range(0, 255)));
        applyStimulus();
        waitIdle();
        compareLogs("ignore");
        checkOutput("err_ignore", 32'(err_cnt), 32'(mErr));
        curFrame = '{8'h03, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 256; i++) curFrame.push_back(8'($urandom_range(0, 255)));
        applyStimulus();
        waitIdle();
        compareLogs("stray");
        checkOutput("err_saturate", 32'(err_cnt), 32'(mErr));

        $display("[TB] reset during FILL");
        readyRandom = 1'b1;
        curFrame = '{8'h03, 8'h77, 8'hFF, 8'h00};
        for (int i = 0; i < 4; i++) sendByte(curFrame[i], i == 0);
        repeat (20) @(negedge clk);
        checkOutput("midfill_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #2;
        checkResetOutputs("midfill_reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        vPtr   = vramLog.size();
        pPtr   = pramLog.size();
        mVaddr = 0;
        mPaddr = 0;
        mErr   = 0;
        expVram.delete();
        expPram.delete();
        curFrame = '{8'h01, 8'hC3};
        applyStimulus();
        waitIdle();
        compareLogs("post_reset");

        $display("[TB] randomized frames");
        gapMax = 2;
        for (int f = 0; f < 30; f++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: op = {5'($urandom_range(0, 31)), 3'd1};
                1: op = {5'($urandom_range(0, 31)), 3'd2};
                2: op = {5'($urandom_range(0, 31)), 3'd3};
                3: op = {5'($urandom_range(0, 31)), 3'd4};
                4: op = {5'($urandom_range(0, 31)), 3'd5};
                default: op = {5'($urandom_range(0, 31)), 3'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(6, 7))};
            endcase
            curFrame.delete();
            curFrame.push_back(op);
            if (kind == 2) begin
                curFrame.push_back(8'($urandom_range(0, 255)));
                curFrame.push_back(8'($urandom_range(0, 6)));
                curFrame.push_back(8'h00);
                if ($urandom_range(0, 5) == 0) begin
                    len = $urandom_range(1, 2);
                    while (curFrame.size() > len + 1) void'(curFrame.pop_back());
                end else begin
                    len = $urandom_range(0, 1);
                    for (int i = 0; i < len; i++) curFrame.push_back(8'($urandom_range(0, 255)));
                end
            end else begin
                if (kind == 1) len = ($urandom_range(0, 5) == 0) ? 1 : 2 + $urandom_range(0, 3);
                else if (kind == 5) len = $urandom_range(0, 3);
                else len = $urandom_range(0, 6);
                for (int i = 0; i < len; i++) curFrame.push_back(8'($urandom_range(0, 255)));
            end
            applyStimulus();
        end
        waitIdle();
        compareLogs("random");
        checkOutput("random_err_cnt", 32'(err_cnt), 32'(mErr));
        checkOutput("no_overlap", 32'(overlapSeen), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
